// File: rtl/demux_reg_pkg.sv
// Shared definitions for the registered 1:N write-side demultiplexer.
// Provides the lane-select width helper and the one-entry lane slot states.
package demux_reg_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_NUM_DATA   = 16;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

    // Ceil(log2(n)) with a floor of 1, so a single-lane build still has a select bit.
    function automatic int unsigned c_log_2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 31; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/demux_reg_if.sv
// Producer/consumer bundle for demux_reg: serial write side and per-lane read side.
interface demux_reg_if
    import demux_reg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_DATA   = DEF_NUM_DATA,
    parameter int unsigned CTRL_WIDTH = c_log_2(NUM_DATA)
);

    logic [DATA_WIDTH-1:0]          data_in;
    logic [CTRL_WIDTH-1:0]          ctrl_in;
    logic                           valid_in;
    logic                           ready_out;
    logic [DATA_WIDTH*NUM_DATA-1:0] data_out;
    logic [NUM_DATA-1:0]            valid_out;
    logic [NUM_DATA-1:0]            ready_in;
    logic                           err_out;

    modport master (
        output data_in,
        output ctrl_in,
        output valid_in,
        input  ready_out,
        input  data_out,
        input  valid_out,
        output ready_in,
        input  err_out
    );

    modport slave (
        input  data_in,
        input  ctrl_in,
        input  valid_in,
        output ready_out,
        output data_out,
        output valid_out,
        input  ready_in,
        output err_out
    );

endinterface

// File: rtl/demux_reg_lane.sv
// One-entry output slot of demux_reg: holds a word until its consumer takes it.
// A write in the same cycle as a drain refills the slot without a bubble.
module demux_lane
    import demux_reg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  full_ready
);

    lane_state_t state;
    lane_state_t state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LANE_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        valid      = (state == LANE_FULL);
        full_ready = (state == LANE_EMPTY) | rd_ready;
        case (state)
            LANE_EMPTY: begin
                if (wr_en) begin
                    state_nxt = LANE_FULL;
                end
            end
            LANE_FULL: begin
                if (!wr_en && rd_ready) begin
                    state_nxt = LANE_EMPTY;
                end
            end
            default: state_nxt = LANE_EMPTY;
        endcase
    end

    // Drained data is left in place; it is only meaningful while valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (wr_en) begin
            data <= wr_data;
        end
    end

endmodule

// File: rtl/demux_reg.sv
// Registered 1:NUM_DATA demultiplexer steering one word per cycle into the lane
// named by ctrl_in; each lane buffers a single word until its consumer drains it.
module demux_reg
    import demux_reg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = DEF_DATA_WIDTH,
    parameter int unsigned NUM_DATA           = DEF_NUM_DATA,
    parameter int unsigned CTRL_WIDTH         = c_log_2(NUM_DATA),
    parameter int unsigned SHUFFLE_DATA_WIDTH = DATA_WIDTH * NUM_DATA
) (
    input  logic       clk,
    input  logic       rst_n,
    demux_reg_if.slave bus
);

    logic [31:0]                   sel_idx;
    logic [NUM_DATA-1:0]           sel;
    logic [NUM_DATA-1:0]           wr_en;
    logic [NUM_DATA-1:0]           lane_rdy;
    logic [NUM_DATA-1:0]           lane_valid;
    logic [SHUFFLE_DATA_WIDTH-1:0] lane_data;
    logic                          in_range;
    logic                          accept;
    logic                          err_q;

    assign sel_idx = 32'(bus.ctrl_in);

    generate
        if (NUM_DATA == (1 << CTRL_WIDTH)) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_partial_range
            assign in_range = (sel_idx < 32'(NUM_DATA));
        end
    endgenerate

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_DATA; i++) begin
            sel[i] = (sel_idx == i);
        end
    end

    // Out-of-range selects are always accepted and dropped so the producer never stalls.
    assign bus.ready_out = ~in_range | (|(sel & lane_rdy));
    assign accept        = bus.valid_in & bus.ready_out;
    assign wr_en         = {NUM_DATA{accept}} & sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept && !in_range) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_out = err_q;

    generate
        for (genvar i = 0; i < NUM_DATA; i++) begin : g_lane
            demux_lane #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_lane (
                .clk        (clk),
                .rst_n      (rst_n),
                .wr_en      (wr_en[i]),
                .wr_data    (bus.data_in),
                .rd_ready   (bus.ready_in[i]),
                .valid      (lane_valid[i]),
                .data       (lane_data[i*DATA_WIDTH +: DATA_WIDTH]),
                .full_ready (lane_rdy[i])
            );
        end
    endgenerate

    assign bus.valid_out = lane_valid;
    assign bus.data_out  = lane_data;

    a_single_write : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(wr_en));

endmodule
